hazard_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage core; sits beside the ID stage.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_ctrl_mem_wait_timer.sv | 29 ++
 rtl/hazard_ctrl.sv | 148 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  // True when an ID source operand depends on the destination of an in-flight load.
  function automatic logic src_match(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] dst
  );
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mem_wait_timer.sv
// Down-counter that paces a multi-cycle SRAM access; loads MEM_WAIT_CYCLES-2 and flags zero.
module mem_wait_timer #(
  parameter int MEM_WAIT_CYCLES = 3,
  parameter int CNT_W           = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  localparam int LOAD_INT = (MEM_WAIT_CYCLES >= 2) ? (MEM_WAIT_CYCLES - 2) : 0;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_INT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, multi-cycle SRAM stalls, branch flushes.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 3,
  parameter int CNT_W           = 2,
  parameter int PERF_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_write_reg,
  input  logic              branch_taken,
  input  logic              mem_req,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              stall_idex,
  output logic              stall_exmem,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              mem_done,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  localparam bit SINGLE_CYCLE = (MEM_WAIT_CYCLES == 1);

  state_t     state, nxt_state;
  logic       branch_pend, nxt_pend;
  logic       tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_cnt;
  logic       load_use;

  logic s_pc, s_ifid, s_idex, s_exmem, f_ifid, f_idex, m_done;

  mem_wait_timer #(
    .MEM_WAIT_CYCLES(MEM_WAIT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(tmr_load),
    .dec (tmr_dec),
    .cnt (tmr_cnt),
    .zero(tmr_zero)
  );

  assign load_use = ex_mem_read && (ex_write_reg != ZERO_REG) &&
                    (src_match(id_uses_rs, id_rs, ex_write_reg) ||
                     src_match(id_uses_rt, id_rt, ex_write_reg));

  // mem_req is a level held for the whole access; mem_done pulses on the single
  // cycle the access finishes, and a mem_req still high on that cycle is ignored.
  always_comb begin
    s_pc      = 1'b0;
    s_ifid    = 1'b0;
    s_idex    = 1'b0;
    s_exmem   = 1'b0;
    f_ifid    = 1'b0;
    f_idex    = 1'b0;
    m_done    = 1'b0;
    nxt_state = state;
    nxt_pend  = branch_pend;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      RUN: begin
        if (mem_req && !SINGLE_CYCLE) begin
          {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
          tmr_load  = 1'b1;
          nxt_state = MEM_WAIT;
          if (branch_taken) nxt_pend = 1'b1;
        end else begin
          m_done = mem_req;
          if (branch_taken) begin
            f_ifid = 1'b1;
            f_idex = 1'b1;
          end else if (load_use) begin
            s_pc   = 1'b1;
            s_ifid = 1'b1;
            f_idex = 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        if (!tmr_zero) begin
          {s_pc, s_ifid, s_idex, s_exmem} = 4'b1111;
          tmr_dec = 1'b1;
          if (branch_taken) nxt_pend = 1'b1;
        end else begin
          // Release: the held EX branch (or one recorded earlier) flushes now.
          m_done    = 1'b1;
          nxt_state = RUN;
          nxt_pend  = 1'b0;
          if (branch_pend || branch_taken) begin
            f_ifid = 1'b1;
            f_idex = 1'b1;
          end else if (load_use) begin
            s_pc   = 1'b1;
            s_ifid = 1'b1;
            f_idex = 1'b1;
          end
        end
      end
      default: nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      branch_pend <= 1'b0;
    end else begin
      state       <= nxt_state;
      branch_pend <= nxt_pend;
    end
  end

  assign stall_pc    = s_pc    && !rst;
  assign stall_ifid  = s_ifid  && !rst;
  assign stall_idex  = s_idex  && !rst;
  assign stall_exmem = s_exmem && !rst;
  assign flush_ifid  = f_ifid  && !rst;
  assign flush_idex  = f_idex  && !rst;
  assign mem_done    = m_done  && !rst;

`ifdef HAZARD_PERF_EN
  // Every IF/ID flush originates from a taken branch, so it doubles as the flush event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_pc)   stall_cycles <= stall_cycles + 1'b1;
      if (flush_ifid) flush_count  <= flush_count + 1'b1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MEM_WAIT_CYCLES=3; expectations hand-computed.
module tb_hazard_ctrl;

  localparam int PERF_W = 32;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs, id_rt, ex_write_reg;
  logic id_uses_rs, id_uses_rt, ex_mem_read, branch_taken, mem_req;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic flush_ifid, flush_idex, mem_done;
  logic [PERF_W-1:0] stall_cycles, flush_count;
  logic [6:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  // Output vector order: {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, mem_done}
  localparam logic [6:0] IDLE  = 7'b0000000;
  localparam logic [6:0] LU    = 7'b1100010;
  localparam logic [6:0] MSTL  = 7'b1111000;
  localparam logic [6:0] MDONE = 7'b0000001;
  localparam logic [6:0] BR    = 7'b0000110;
  localparam logic [6:0] BRDN  = 7'b0000111;
  localparam logic [6:0] LUDN  = 7'b1100011;

  hazard_ctrl #(
    .MEM_WAIT_CYCLES(3),
    .CNT_W          (2),
    .PERF_W         (PERF_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_write_reg(ex_write_reg),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .stall_idex  (stall_idex),
    .stall_exmem (stall_exmem),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .mem_done    (mem_done),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  assign outs = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, mem_done};

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs are set just after a rising edge, outputs sampled on the falling edge
  task automatic step(input string tag, input logic [6:0] exp);
    @(negedge clk);
    check(tag, {25'd0, outs}, {25'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_write_reg = 5'd0; branch_taken = 1'b0; mem_req = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] reg_n);
    ex_mem_read = 1'b1; ex_write_reg = reg_n; id_rs = reg_n; id_uses_rs = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [31:0] exp_stalls, exp_flushes;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {25'd0, outs}, 32'd0);
    check("reset_stall_cycles", stall_cycles, 32'd0);
    check("reset_flush_count", flush_count, 32'd0);
    rst = 1'b0;
    step("idle_after_reset", IDLE);

    // load-use on rs: exactly one bubble, hazard gone once EX holds the NOP
    set_load_use(5'd8);
    step("load_use_rs", LU);
    ex_mem_read = 1'b0;
    step("load_use_cleared", IDLE);
    set_load_use(5'd0);
    step("load_use_zero_reg", IDLE);
    idle_inputs();
    ex_mem_read = 1'b1; ex_write_reg = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    step("load_use_rt", LU);
    id_uses_rt = 1'b0;
    step("no_use_no_stall", IDLE);
    idle_inputs();

    // SRAM access followed immediately by a second one
    mem_req = 1'b1;
    step("mem_c0", MSTL);
    step("mem_c1", MSTL);
    step("mem_release", MDONE);
    step("mem2_c0", MSTL);
    step("mem2_c1", MSTL);
    step("mem2_release", MDONE);
    mem_req = 1'b0;
    step("mem_idle", IDLE);

    // branch in RUN, and branch masking a load-use
    branch_taken = 1'b1;
    step("branch_run", BR);
    set_load_use(5'd4);
    step("branch_masks_lu", BR);
    idle_inputs();
    step("branch_gone", IDLE);

    // branch arriving during the wait is deferred to the release cycle
    mem_req = 1'b1;
    step("mbr_c0", MSTL);
    branch_taken = 1'b1;
    step("mbr_c1", MSTL);
    branch_taken = 1'b0;
    step("mbr_release", BRDN);
    mem_req = 1'b0;
    step("mbr_after", IDLE);

    // load-use during the wait is only acted on at release
    mem_req = 1'b1;
    set_load_use(5'd12);
    step("mlu_c0", MSTL);
    step("mlu_c1", MSTL);
    step("mlu_release", LUDN);
    idle_inputs();
    step("mlu_after", IDLE);

    // asynchronous reset in the middle of a wait
    mem_req = 1'b1;
    step("rst_c0", MSTL);
    rst = 1'b1;
    #1;
    check("rst_async_outs", {25'd0, outs}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_req = 1'b0;
    step("rst_back_run", IDLE);
    mem_req = 1'b1;
    step("rst_new_c0", MSTL);
    step("rst_new_c1", MSTL);
    step("rst_new_release", MDONE);
    mem_req = 1'b0;

    // performance counters over a short, known sequence
    pulse_reset();
    set_load_use(5'd8);
    step("perf_lu", LU);
    idle_inputs();
    branch_taken = 1'b1;
    step("perf_br", BR);
    branch_taken = 1'b0;
    mem_req = 1'b1;
    step("perf_m0", MSTL);
    branch_taken = 1'b1;
    step("perf_m1", MSTL);
    branch_taken = 1'b0;
    step("perf_release", BRDN);
    mem_req = 1'b0;
    step("perf_idle", IDLE);
`ifdef HAZARD_PERF_EN
    exp_stalls  = 32'd3;
    exp_flushes = 32'd2;
`else
    exp_stalls  = 32'd0;
    exp_flushes = 32'd0;
`endif
    check("perf_stall_cycles", stall_cycles, exp_stalls);
    check("perf_flush_count", flush_count, exp_flushes);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
